// File: rtl/issue_pkg.sv
// Shared definitions for the issue slot: state encoding, i_data field offsets
// and the packed-width formulas used by the slot and its wakeup comparators.
package issue_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ISSUED = 2'd2
    } slot_state_e;

    localparam int UOP_W   = 7;
    localparam int OFF_P1  = 0;
    localparam int OFF_P2  = 1;
    localparam int OFF_VAL = 2;
    localparam int OFF_PRY = 3;

    function automatic int calc_width_i(int w_brm, int w_tag, int w_reg, int w_pry);
        return UOP_W + w_brm + w_tag + 3 * w_reg + w_pry + 3;
    endfunction

    function automatic int calc_width_o(int w_brm, int w_tag, int w_reg);
        return UOP_W + w_brm + w_tag + 2 + 3 * w_reg;
    endfunction

    // Offsets of the upper fields depend on the priority and register widths.
    function automatic int off_rs1(int w_pry);
        return OFF_PRY + w_pry;
    endfunction

    function automatic int off_rs2(int w_pry, int w_reg);
        return off_rs1(w_pry) + w_reg;
    endfunction

    function automatic int off_rd(int w_pry, int w_reg);
        return off_rs1(w_pry) + 2 * w_reg;
    endfunction

    function automatic int off_tag(int w_pry, int w_reg);
        return off_rs1(w_pry) + 3 * w_reg;
    endfunction

    function automatic int off_brm(int w_pry, int w_reg, int w_tag);
        return off_tag(w_pry, w_reg) + w_tag;
    endfunction

    function automatic int off_uop(int w_pry, int w_reg, int w_tag, int w_brm);
        return off_brm(w_pry, w_reg, w_tag) + w_brm;
    endfunction

endpackage

// File: rtl/wakeup_match.sv
// One source operand compared against every wakeup port; a port only
// participates while its valid bit is high.
module wakeup_match #(
    parameter int WIDTH_REG = 5,
    parameter int N_WAKE    = 4
) (
    input  logic [WIDTH_REG-1:0]        i_src,
    input  logic [N_WAKE*WIDTH_REG-1:0] i_wdest,
    input  logic [N_WAKE-1:0]           i_wvalid,
    output logic                        o_match
);

    logic [N_WAKE-1:0] w_hit;

    for (genvar k = 0; k < N_WAKE; k++) begin : g_port
        assign w_hit[k] = i_wvalid[k] && (i_wdest[k*WIDTH_REG +: WIDTH_REG] == i_src);
    end

    assign o_match = |w_hit;

endmodule

// File: rtl/issue_slot_gen.sv
// Single reservation-station slot: holds one micro-op, tracks operand
// readiness via wakeup, branch kill/clear, select/issue handshake and age.
module issue_slot_gen
    import issue_pkg::*;
#(
    parameter int         WIDTH_REG = 5,
    parameter int         WIDTH_TAG = 5,
    parameter int         WIDTH_BRM = 4,
    parameter int         WIDTH_PRY = 2,
    parameter int         WIDTH_AGE = 3,
    parameter int         N_WAKE    = 4,
    parameter logic [1:0] TAG_BANK  = 2'b00,
    localparam int        WIDTH_I   = calc_width_i(WIDTH_BRM, WIDTH_TAG, WIDTH_REG, WIDTH_PRY),
    localparam int        WIDTH_O   = calc_width_o(WIDTH_BRM, WIDTH_TAG, WIDTH_REG)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [WIDTH_I-1:0]          i_data,
    input  logic                        i_en,
    input  logic [N_WAKE*WIDTH_REG-1:0] i_WDest,
    input  logic [N_WAKE-1:0]           i_wvalid,
    input  logic [WIDTH_BRM-1:0]        i_brkill,
    input  logic [WIDTH_BRM-1:0]        i_brclear,
    input  logic                        i_grant,
    input  logic                        i_ack,
    input  logic                        i_nack,
    output logic                        o_request,
    output logic [WIDTH_PRY-1:0]        o_priority,
    output logic [WIDTH_AGE-1:0]        o_age,
    output logic                        o_busy,
    output logic [WIDTH_O-1:0]          o_rslot,
    output logic [WIDTH_I-1:0]          o_data
);

    localparam int O_RS1 = off_rs1(WIDTH_PRY);
    localparam int O_RS2 = off_rs2(WIDTH_PRY, WIDTH_REG);
    localparam int O_RD  = off_rd(WIDTH_PRY, WIDTH_REG);
    localparam int O_TAG = off_tag(WIDTH_PRY, WIDTH_REG);
    localparam int O_BRM = off_brm(WIDTH_PRY, WIDTH_REG, WIDTH_TAG);
    localparam int O_UOP = off_uop(WIDTH_PRY, WIDTH_REG, WIDTH_TAG, WIDTH_BRM);

    slot_state_e          r_state;
    logic                 r_p1;
    logic                 r_p2;
    logic [WIDTH_AGE-1:0] r_age;
    logic [WIDTH_BRM-1:0] r_brmask;
    logic [UOP_W-1:0]     r_uop;
    logic [WIDTH_TAG-1:0] r_tag;
    logic [WIDTH_REG-1:0] r_rd;
    logic [WIDTH_REG-1:0] r_rs2;
    logic [WIDTH_REG-1:0] r_rs1;
    logic [WIDTH_PRY-1:0] r_pry;

    logic [UOP_W-1:0]     w_in_uop;
    logic [WIDTH_BRM-1:0] w_in_brm;
    logic [WIDTH_TAG-1:0] w_in_tag;
    logic [WIDTH_REG-1:0] w_in_rd;
    logic [WIDTH_REG-1:0] w_in_rs2;
    logic [WIDTH_REG-1:0] w_in_rs1;
    logic [WIDTH_PRY-1:0] w_in_pry;
    logic                 w_in_val;
    logic                 w_in_p2;
    logic                 w_in_p1;

    assign w_in_uop = i_data[O_UOP +: UOP_W];
    assign w_in_brm = i_data[O_BRM +: WIDTH_BRM];
    assign w_in_tag = i_data[O_TAG +: WIDTH_TAG];
    assign w_in_rd  = i_data[O_RD  +: WIDTH_REG];
    assign w_in_rs2 = i_data[O_RS2 +: WIDTH_REG];
    assign w_in_rs1 = i_data[O_RS1 +: WIDTH_REG];
    assign w_in_pry = i_data[OFF_PRY +: WIDTH_PRY];
    assign w_in_val = i_data[OFF_VAL];
    assign w_in_p2  = i_data[OFF_P2];
    assign w_in_p1  = i_data[OFF_P1];

    // A write compares the wakeup bus against the incoming sources, not the held ones.
    logic [WIDTH_REG-1:0] w_cmp_rs1;
    logic [WIDTH_REG-1:0] w_cmp_rs2;
    logic                 w_wake1;
    logic                 w_wake2;

    assign w_cmp_rs1 = i_en ? w_in_rs1 : r_rs1;
    assign w_cmp_rs2 = i_en ? w_in_rs2 : r_rs2;

    wakeup_match #(.WIDTH_REG(WIDTH_REG), .N_WAKE(N_WAKE)) u_wake_rs1 (
        .i_src    (w_cmp_rs1),
        .i_wdest  (i_WDest),
        .i_wvalid (i_wvalid),
        .o_match  (w_wake1)
    );

    wakeup_match #(.WIDTH_REG(WIDTH_REG), .N_WAKE(N_WAKE)) u_wake_rs2 (
        .i_src    (w_cmp_rs2),
        .i_wdest  (i_WDest),
        .i_wvalid (i_wvalid),
        .o_match  (w_wake2)
    );

    logic w_fire;
    logic w_kill;

    assign o_request = (r_state == ST_WAIT) && r_p1 && r_p2;
    assign w_fire    = o_request && i_grant;
    assign w_kill    = |(r_brmask & i_brkill);

    slot_state_e          w_state_n;
    logic                 w_p1_n;
    logic                 w_p2_n;
    logic [WIDTH_AGE-1:0] w_age_n;
    logic [WIDTH_BRM-1:0] w_brm_n;
    logic [UOP_W-1:0]     w_uop_n;
    logic [WIDTH_TAG-1:0] w_tag_n;
    logic [WIDTH_REG-1:0] w_rd_n;
    logic [WIDTH_REG-1:0] w_rs2_n;
    logic [WIDTH_REG-1:0] w_rs1_n;
    logic [WIDTH_PRY-1:0] w_pry_n;

    always_comb begin
        w_state_n = r_state;
        w_p1_n    = r_p1 | w_wake1;
        w_p2_n    = r_p2 | w_wake2;
        w_age_n   = r_age;
        w_brm_n   = r_brmask & ~i_brclear;
        w_uop_n   = r_uop;
        w_tag_n   = r_tag;
        w_rd_n    = r_rd;
        w_rs2_n   = r_rs2;
        w_rs1_n   = r_rs1;
        w_pry_n   = r_pry;
        if (i_en) begin
            // Kill is tested on the raw incoming mask, so kill beats a same-cycle clear.
            w_state_n = (w_in_val && !(|(w_in_brm & i_brkill))) ? ST_WAIT : ST_EMPTY;
            w_p1_n    = w_in_p1 | w_wake1;
            w_p2_n    = w_in_p2 | w_wake2;
            w_age_n   = '0;
            w_brm_n   = w_in_brm & ~i_brclear;
            w_uop_n   = w_in_uop;
            w_tag_n   = w_in_tag;
            w_rd_n    = w_in_rd;
            w_rs2_n   = w_in_rs2;
            w_rs1_n   = w_in_rs1;
            w_pry_n   = w_in_pry;
        end else begin
            if (o_request && !i_grant && (r_age != '1)) begin
                w_age_n = r_age + 1'b1;
            end
            case (r_state)
                ST_WAIT: begin
                    if (w_kill)      w_state_n = ST_EMPTY;
                    else if (w_fire) w_state_n = ST_ISSUED;
                end
                ST_ISSUED: begin
                    if (w_kill)      w_state_n = ST_EMPTY;
                    else if (i_nack) w_state_n = ST_WAIT;
                    else if (i_ack)  w_state_n = ST_EMPTY;
                end
                ST_EMPTY: w_state_n = ST_EMPTY;
                default:  w_state_n = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= ST_EMPTY;
            r_p1     <= 1'b0;
            r_p2     <= 1'b0;
            r_age    <= '0;
            r_brmask <= '0;
        end else begin
            r_state  <= w_state_n;
            r_p1     <= w_p1_n;
            r_p2     <= w_p2_n;
            r_age    <= w_age_n;
            r_brmask <= w_brm_n;
        end
    end

    // Payload carries no reset; it is meaningless while the slot is empty.
    always_ff @(posedge i_clk) begin
        r_uop <= w_uop_n;
        r_tag <= w_tag_n;
        r_rd  <= w_rd_n;
        r_rs2 <= w_rs2_n;
        r_rs1 <= w_rs1_n;
        r_pry <= w_pry_n;
    end

    assign o_priority = r_pry;
    assign o_age      = r_age;
    assign o_busy     = (r_state != ST_EMPTY);
    assign o_rslot    = {WIDTH_O{w_fire}} & {r_uop, r_brmask, r_tag, TAG_BANK, r_rd, r_rs2, r_rs1};
    assign o_data     = {w_uop_n, w_brm_n, w_tag_n, w_rd_n, w_rs2_n, w_rs1_n, w_pry_n,
                         (w_state_n != ST_EMPTY), w_p2_n, w_p1_n};

endmodule

// File: doc/issue_slot_gen.md
ISSUE_SLOT_GEN -- requirements
Module: issue_slot_gen

Interface
REQ-001 SHALL have parameter WIDTH_REG, default 5, meaning physical register index width.
REQ-002 SHALL have parameter WIDTH_TAG, default 5, meaning ROB tag width.
REQ-003 SHALL have parameter WIDTH_BRM, default 4, meaning branch mask width (one bit per outstanding branch).
REQ-004 SHALL have parameter WIDTH_PRY, default 2, meaning static priority width.
REQ-005 SHALL have parameter WIDTH_AGE, default 3, meaning age counter width.
REQ-006 SHALL have parameter N_WAKE, default 4, meaning number of wakeup ports.
REQ-007 SHALL have parameter TAG_BANK, default 2'b00, meaning 2-bit bank id appended to o_rslot.
REQ-008 SHALL have WIDTH_I = 7+WIDTH_BRM+WIDTH_TAG+3*WIDTH_REG+WIDTH_PRY+3 and WIDTH_O = 7+WIDTH_BRM+WIDTH_TAG+2+3*WIDTH_REG.
REQ-009 SHALL have port i_clk, input, 1 bit, the single clock; reset is synchronous and active-low.
REQ-010 SHALL have port i_rst_n, input, 1 bit, synchronous active-low reset.
REQ-011 SHALL have port i_data, input, WIDTH_I bits: {UOPCode[7], BrMask, Tag, RD, RS2, RS1, PRY, val, p2, p1}, p1 at bit 0.
REQ-012 SHALL have port i_en, input, 1 bit, write i_data into the slot.
REQ-013 SHALL have ports i_WDest (N_WAKE*WIDTH_REG) and i_wvalid (N_WAKE), inputs, for per-port wakeup destination and valid.
REQ-014 SHALL have ports i_brkill and i_brclear, inputs, WIDTH_BRM bits each: mispredicted and resolved-correct branch bits.
REQ-015 SHALL have ports i_grant, i_ack and i_nack, inputs, 1 bit each: select grant, issue confirmed, issue replay.
REQ-016 SHALL have output o_request (1 bit), o_priority (WIDTH_PRY), o_age (WIDTH_AGE), o_busy (1 bit, state != EMPTY).
REQ-017 SHALL have output o_rslot, WIDTH_O bits: {UOPCode, BrMask, Tag, TAG_BANK, RD, RS2, RS1}.
REQ-018 SHALL have output o_data, WIDTH_I bits: next-state image in i_data layout, used for compaction.

Function
REQ-019 SHALL implement states EMPTY, WAIT and ISSUED.
REQ-020 SHALL set o_request = (state==WAIT) & p1 & p2, combinationally from registered state.
REQ-021 SHALL set wake_k = i_wvalid[k] & (WDest_k == RSx); px_next = px | any wake_k. Ports with i_wvalid low SHALL never match.
REQ-022 SHALL, on i_en, load all fields, set state to WAIT if val else EMPTY, and set p1/p2 to i_p1/i_p2 OR'd with same-cycle wakeup matches against the incoming RS1/RS2.
REQ-023 SHALL, on i_en, apply same-cycle i_brclear to the incoming BrMask and set the state to EMPTY if the incoming BrMask & i_brkill is nonzero.
REQ-024 SHALL go WAIT->ISSUED on i_grant & o_request; i_grant without o_request SHALL be ignored.
REQ-025 SHALL go ISSUED->EMPTY on i_ack, ISSUED->WAIT on i_nack, keeping p1/p2; i_ack and i_nack together SHALL be treated as nack.
REQ-026 SHALL, in any non-EMPTY state, go to EMPTY next cycle if |(BrMask & i_brkill); kill SHALL beat grant, ack and nack.
REQ-027 SHALL update BrMask each cycle as BrMask & ~i_brclear; a bit both killed and cleared in one cycle SHALL kill.
REQ-028 SHALL give i_en priority over every other event; no other event SHALL modify the newly loaded entry except as stated in REQ-022/023.
REQ-029 SHALL reset the age counter to 0 on i_en, increment it saturating at all-ones each cycle o_request=1 and i_grant=0, and hold it otherwise.
REQ-030 SHALL drive o_rslot with the slot fields when i_grant & o_request, else all zeros (AND-OR bus, no tri-state).
REQ-031 SHALL set o_data = {next fields, next BrMask, val_next=(state_next!=EMPTY), p2_next, p1_next}.

Reset
REQ-032 SHALL, on i_rst_n=0 at a clock edge, set state EMPTY, p1=p2=0, age=0 and BrMask=0, giving o_request=0, o_busy=0 and o_rslot=0; payload fields are don't-care.
REQ-033 SHALL let reset override i_en and every other input in the same cycle.

Structure
REQ-034 SHALL place the state encoding, the i_data field offsets and the WIDTH_I/WIDTH_O formulas in shared package issue_pkg.
REQ-035 SHALL implement wakeup as sub-module wakeup_match (N_WAKE comparators gated by valid, OR-reduced), instantiated once per source.

Verification
REQ-036 SHALL cover: write RS1=3, RS2=7 with p1=p2=0, then i_WDest port2=7 with i_wvalid=0100 -> p2=1 next cycle, o_request stays 0 until RS1=3 wakes.
REQ-037 SHALL cover: i_en with RS1=5, p1=0 and same-cycle wake on port0=5 -> p1=1 in the first valid cycle.
REQ-038 SHALL cover: WAIT with request=1, grant -> ISSUED and o_rslot nonzero during grant; then i_nack -> WAIT with o_request=1; then grant plus i_ack -> EMPTY.
REQ-039 SHALL cover: BrMask=0110 with i_brclear=0010 -> BrMask=0100; then i_brkill=0100 together with i_grant -> EMPTY, o_request=0.
REQ-040 SHALL cover: request held 9 cycles with no grant and WIDTH_AGE=3 -> o_age saturates at 7; i_en -> o_age=0.
REQ-041 SHALL cover: i_rst_n=0 asserted in ISSUED together with i_en -> EMPTY and all outputs at reset values next cycle.
